// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   DEFAULT_RESET_PC  - PC of the first fetch after reset
//   DEFAULT_NOP_INSTR - bubble instruction shown to decode (addi x0,x0,0)
//   fetch_state_t     - fetch control states
//   align_word()      - clears the byte-offset bits of an address
package fetch_stage_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] WORD_MASK         = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_STALL
    } fetch_state_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// F/D boundary bundle between the fetch stage and decode.
//   valid    - bundle holds a real instruction
//   instr    - fetched instruction (NOP when not valid)
//   pc       - PC of instr
//   pc_plus4 - pc + 4
// master: driven by fetch; slave: consumed by decode.
interface data_fetch_io;

    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    modport master (output valid, instr, pc, pc_plus4);
    modport slave  (input  valid, instr, pc, pc_plus4);

endinterface

// File: rtl/fetch_stage_hold.sv
// Hold register and instruction output mux for the F/D boundary.
// The instruction memory answers one cycle after a request and is not
// re-read while stalled, so the word present on the first stalled cycle
// is captured here and replayed until the stall ends.
// Ports:
//   clk, rstn   - clock, synchronous active-low reset
//   squash      - bundle is being replaced by a bubble (flush or redirect)
//   stall       - F/D bundle is being held
//   valid_d     - current bundle is a real instruction
//   imem_rdata  - memory read data (answer to last cycle's request)
//   instr_d     - instruction presented to decode
module fetch_hold_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        squash,
    input  logic        stall,
    input  logic        valid_d,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_d
);

    logic        held;
    logic [31:0] hold_instr;

    // Capture only on the first stalled cycle; later cycles see stale or
    // garbage read data because no request is outstanding.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            held       <= 1'b0;
            hold_instr <= NOP_INSTR;
        end else if (squash) begin
            held <= 1'b0;
        end else if (stall) begin
            if (!held) begin
                hold_instr <= imem_rdata;
                held       <= 1'b1;
            end
        end else begin
            held <= 1'b0;
        end
    end

    // Reset forces a NOP immediately so nothing stale leaks into decode.
    always_comb begin
        instr_d = imem_rdata;
        if (!rstn || !valid_d) begin
            instr_d = NOP_INSTR;
        end else if (held) begin
            instr_d = hold_instr;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the 1-cycle-latency
// instruction memory and registers the bundle at the F/D boundary.
// Ports:
//   clk, rstn        - clock, synchronous active-low reset
//   stall_f          - hold PC and F/D bundle
//   flush_d          - replace the F/D bundle by a bubble
//   pc_src/pc_target - redirect request from EX and its target
//   imem_en/addr     - instruction memory request
//   imem_rdata       - memory read data, one cycle after imem_en
//   dec              - bundle to decode (valid, instr, pc, pc_plus4)
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         stall_f,
    input  logic         flush_d,
    input  logic         pc_src,
    input  logic [31:0]  pc_target,
    output logic         imem_en,
    output logic [31:0]  imem_addr,
    input  logic [31:0]  imem_rdata,
    data_fetch_io.master dec
);

    fetch_state_t state_q;
    fetch_state_t state_d;

    logic [31:0] pc_f;
    logic [31:0] pc_next;
    logic        valid_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic [31:0] instr_d;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // A redirect pulls the stage out of a stall even while stall_f is high.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN:   if (stall_f && !pc_src) state_d = S_STALL;
            S_STALL: if (!stall_f || pc_src) state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    assign imem_en   = (state_q != S_BOOT) && !stall_f && rstn;
    assign imem_addr = pc_f;

    // The PC advances exactly when a read is issued, so the first unstalled
    // cycle after a stall moves on instead of re-reading the same word.
    always_comb begin
        pc_next = pc_f;
        if (pc_src) begin
            pc_next = align_word(pc_target);
        end else if (imem_en) begin
            pc_next = pc_f + 32'd4;
        end
    end

    // On flush/redirect pc_d and pc_plus4_d keep their old values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc_f       <= RESET_PC;
            valid_d    <= 1'b0;
            pc_d       <= 32'h0;
            pc_plus4_d <= 32'h0;
        end else begin
            pc_f <= pc_next;
            if (flush_d || pc_src) begin
                valid_d <= 1'b0;
            end else if (!stall_f) begin
                pc_d       <= pc_f;
                pc_plus4_d <= pc_f + 32'd4;
                valid_d    <= imem_en;
            end
        end
    end

    fetch_hold_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_hold (
        .clk        (clk),
        .rstn       (rstn),
        .squash     (flush_d || pc_src),
        .stall      (stall_f),
        .valid_d    (valid_d),
        .imem_rdata (imem_rdata),
        .instr_d    (instr_d)
    );

    assign dec.valid    = valid_d;
    assign dec.instr    = instr_d;
    assign dec.pc       = pc_d;
    assign dec.pc_plus4 = pc_plus4_d;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. A program-level model predicts the
// address sequence and the bundles that must reach decode; a monitor on the
// falling edge compares DUT outputs against those predictions.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam logic [31:0] MEM_KEY = 32'hA5A5_0000;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic        clk       = 1'b0;
    logic        rstn      = 1'b0;
    logic        stall_f   = 1'b0;
    logic        flush_d   = 1'b0;
    logic        pc_src    = 1'b0;
    logic [31:0] pc_target = 32'h0;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;

    data_fetch_io dec_if ();

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .stall_f    (stall_f),
        .flush_d    (flush_d),
        .pc_src     (pc_src),
        .pc_target  (pc_target),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .dec        (dec_if)
    );

    always #5 clk = ~clk;

    // Memory answers addr^KEY one cycle after a request; garbage otherwise.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= imem_addr ^ MEM_KEY;
        else         imem_rdata <= $urandom;
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        int          cyc;
    } bundle_t;

    bundle_t     bund_q[$];
    logic [31:0] addr_q[$];
    int          checks      = 0;
    int          errors      = 0;
    int          cycle_count = 0;
    logic [31:0] m_pc        = 32'h0;
    logic        m_boot      = 1'b1;

    always @(posedge clk) cycle_count <= cycle_count + 1;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of controls and advance the program-level model:
    // a read happens on every running, unstalled cycle; it reaches decode
    // unless flushed or redirected in the same cycle.
    task automatic apply_stimulus(input logic r, input logic s, input logic f,
                                  input logic p, input logic [31:0] t);
        logic    fetch;
        bundle_t b;
        @(posedge clk);
        #1;
        rstn      = r;
        stall_f   = s;
        flush_d   = f;
        pc_src    = p;
        pc_target = t;
        if (!r) begin
            addr_q.delete();
            bund_q.delete();
            m_pc   = 32'h0;
            m_boot = 1'b1;
        end else begin
            fetch = !m_boot && !s;
            if (fetch) begin
                addr_q.push_back(m_pc);
                if (!f && !p) begin
                    b.pc    = m_pc;
                    b.pc4   = m_pc + 32'd4;
                    b.instr = m_pc ^ MEM_KEY;
                    b.cyc   = cycle_count;
                    bund_q.push_back(b);
                end
            end
            if (p)          m_pc = t & 32'hFFFF_FFFC;
            else if (fetch) m_pc = m_pc + 32'd4;
            m_boot = 1'b0;
        end
    endtask

    // A bundle stays in decode until a cycle that is unstalled, flushed or
    // redirected; it must look identical on every cycle it is shown.
    always @(negedge clk) begin
        logic    due;
        bundle_t head;
        if (!rstn) begin
            check_output("rst_instr", dec_if.instr, NOP);
            check_output("rst_imem_en", {31'b0, imem_en}, 32'd0);
        end else begin
            check_output("imem_en", {31'b0, imem_en}, {31'b0, addr_q.size() != 0});
            if (addr_q.size() != 0) begin
                if (imem_en) check_output("imem_addr", imem_addr, addr_q[0]);
                addr_q.delete(0);
            end
            due = (bund_q.size() != 0) && (bund_q[0].cyc < cycle_count);
            check_output("valid_d", {31'b0, dec_if.valid}, {31'b0, due});
            if (due) begin
                head = bund_q[0];
                if (dec_if.valid) begin
                    check_output("pc_d", dec_if.pc, head.pc);
                    check_output("pc_plus4_d", dec_if.pc_plus4, head.pc4);
                    check_output("instr_d", dec_if.instr, head.instr);
                end
                if (!stall_f || flush_d || pc_src) bund_q.delete(0);
            end else if (!dec_if.valid) begin
                check_output("bubble_instr", dec_if.instr, NOP);
            end
        end
    end

    initial begin
        // Reset and free run
        apply_stimulus(0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        check_output("reset_valid", {31'b0, dec_if.valid}, 32'd0);
        check_output("reset_pc_d", dec_if.pc, 32'h0);
        check_output("reset_pc_plus4_d", dec_if.pc_plus4, 32'h0);
        apply_stimulus(1, 0, 0, 0, 0);
        @(negedge clk);
        check_output("boot_no_request", {31'b0, imem_en}, 32'd0);
        apply_stimulus(1, 0, 0, 0, 0);
        @(negedge clk);
        check_output("first_fetch_en", {31'b0, imem_en}, 32'd1);
        check_output("first_fetch_addr", imem_addr, 32'h0);
        apply_stimulus(1, 0, 0, 0, 0);
        @(negedge clk);
        check_output("first_valid", {31'b0, dec_if.valid}, 32'd1);
        check_output("first_pc_d", dec_if.pc, 32'h0);
        check_output("first_pc_plus4", dec_if.pc_plus4, 32'h4);
        check_output("first_instr", dec_if.instr, 32'hA5A5_0000);
        apply_stimulus(1, 0, 0, 0, 0);

        // Three-cycle stall while pc_d = 0x8; memory output is garbage
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1, 1, 0, 0, 0);
            @(negedge clk);
            check_output("stall_en", {31'b0, imem_en}, 32'd0);
            check_output("stall_pc_d", dec_if.pc, 32'h8);
            check_output("stall_instr", dec_if.instr, 32'h8 ^ MEM_KEY);
        end
        apply_stimulus(1, 0, 0, 0, 0);
        @(negedge clk);
        check_output("resume_addr", imem_addr, 32'hC);
        check_output("resume_instr", dec_if.instr, 32'h8 ^ MEM_KEY);

        // Redirect to an unaligned target while fetching 0x10
        apply_stimulus(1, 0, 0, 1, 32'h103);
        @(negedge clk);
        check_output("redirect_cur_addr", imem_addr, 32'h10);
        apply_stimulus(1, 0, 0, 0, 0);
        @(negedge clk);
        check_output("redirect_addr", imem_addr, 32'h100);
        check_output("redirect_bubble", {31'b0, dec_if.valid}, 32'd0);
        apply_stimulus(1, 0, 0, 0, 0);
        @(negedge clk);
        check_output("redirect_valid", {31'b0, dec_if.valid}, 32'd1);
        check_output("redirect_pc_d", dec_if.pc, 32'h100);
        check_output("redirect_instr", dec_if.instr, 32'h100 ^ MEM_KEY);

        // Redirect during a stall wins; the read issues once stall drops
        apply_stimulus(1, 1, 0, 0, 0);
        apply_stimulus(1, 1, 0, 1, 32'h100);
        apply_stimulus(1, 1, 0, 0, 0);
        @(negedge clk);
        check_output("stall_redirect_addr", imem_addr, 32'h100);
        check_output("stall_redirect_valid", {31'b0, dec_if.valid}, 32'd0);
        apply_stimulus(1, 0, 0, 0, 0);
        @(negedge clk);
        check_output("stall_redirect_en", {31'b0, imem_en}, 32'd1);
        check_output("stall_redirect_fetch", imem_addr, 32'h100);
        apply_stimulus(1, 0, 0, 0, 0);
        @(negedge clk);
        check_output("stall_redirect_pc_d", dec_if.pc, 32'h100);

        // Single flush pulse: one bubble, PC sequence unbroken
        apply_stimulus(1, 0, 1, 0, 0);
        @(negedge clk);
        check_output("flush_cur_addr", imem_addr, 32'h108);
        apply_stimulus(1, 0, 0, 0, 0);
        @(negedge clk);
        check_output("flush_bubble_valid", {31'b0, dec_if.valid}, 32'd0);
        check_output("flush_bubble_instr", dec_if.instr, NOP);
        check_output("flush_pc_seq", imem_addr, 32'h10C);
        apply_stimulus(1, 0, 0, 0, 0);
        @(negedge clk);
        check_output("flush_after_pc_d", dec_if.pc, 32'h10C);

        // PC wrap at the top of the address space
        apply_stimulus(1, 0, 0, 1, 32'hFFFF_FFFC);
        apply_stimulus(1, 0, 0, 0, 0);
        @(negedge clk);
        check_output("wrap_addr_hi", imem_addr, 32'hFFFF_FFFC);
        apply_stimulus(1, 0, 0, 0, 0);
        @(negedge clk);
        check_output("wrap_addr", imem_addr, 32'h0);
        check_output("wrap_pc_d", dec_if.pc, 32'hFFFF_FFFC);
        check_output("wrap_pc_plus4", dec_if.pc_plus4, 32'h0);

        // Reset mid-run
        apply_stimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        check_output("midrst_instr", dec_if.instr, NOP);
        check_output("midrst_en", {31'b0, imem_en}, 32'd0);
        apply_stimulus(1, 0, 0, 0, 0);
        @(negedge clk);
        check_output("midrst_valid", {31'b0, dec_if.valid}, 32'd0);
        check_output("midrst_pc_f", imem_addr, 32'h0);
        check_output("midrst_boot_en", {31'b0, imem_en}, 32'd0);
        apply_stimulus(1, 0, 0, 0, 0);
        @(negedge clk);
        check_output("midrst_first_addr", imem_addr, 32'h0);
        check_output("midrst_no_stale", {31'b0, dec_if.valid}, 32'd0);
        apply_stimulus(1, 0, 0, 0, 0);
        @(negedge clk);
        check_output("midrst_first_instr", dec_if.instr, MEM_KEY);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            if ($urandom_range(0, 15) == 0) tgt = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            else                            tgt = $urandom_range(0, 4095);
            apply_stimulus($urandom_range(0, 255) != 0,
                           $urandom_range(0, 3) == 0,
                           $urandom_range(0, 9) == 0,
                           $urandom_range(0, 11) == 0,
                           tgt);
        end

        // Drain: stop fetching, squash what remains, expect nothing pending
        apply_stimulus(1, 1, 0, 0, 0);
        apply_stimulus(1, 1, 1, 0, 0);
        apply_stimulus(1, 1, 0, 0, 0);
        @(negedge clk);
        #1;
        check_output("drain_addr_q", 32'(addr_q.size()), 32'd0);
        check_output("drain_bundle_q", 32'(bund_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
